// File: rtl/rc4_check_pkg.sv
// Shared types and character-class constants for the decrypted-message checker.
// The CHECK_ALLOW_UPPER_EN macro is read only by char_validator.
package rc4_check_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MONITOR  = 3'd1,
    ST_WAIT_FIN = 3'd2,
    ST_BAD      = 3'd3,
    ST_FOUND    = 3'd4
  } checker_state_t;

  localparam logic [7:0] CHAR_SPACE  = 8'h20;
  localparam logic [7:0] CHAR_LO_MIN = 8'h61;
  localparam logic [7:0] CHAR_LO_MAX = 8'h7A;
  localparam logic [7:0] CHAR_UP_MIN = 8'h41;
  localparam logic [7:0] CHAR_UP_MAX = 8'h5A;

endpackage

// File: rtl/char_validator.sv
// Combinational legality test for one decrypted byte: space or lowercase,
// plus uppercase when CHECK_ALLOW_UPPER_EN is defined.
module char_validator
  import rc4_check_pkg::*;
(
  input  logic [7:0] data,
  output logic       legal
);

  logic is_space;
  logic is_lower;
  logic is_upper;

  assign is_space = (data == CHAR_SPACE);
  assign is_lower = (data >= CHAR_LO_MIN) && (data <= CHAR_LO_MAX);
  assign is_upper = (data >= CHAR_UP_MIN) && (data <= CHAR_UP_MAX);

`ifdef CHECK_ALLOW_UPPER_EN
  assign legal = is_space || is_lower || is_upper;
`else
  assign legal = is_space || is_lower;
  logic unused_upper;
  assign unused_upper = is_upper;
`endif

endmodule

// File: rtl/decrypted_message_checker.sv
// Snoops the decrypted-RAM write port, aborts the decryptor on the first bad byte
// or out-of-order address, and reports found/bad verdicts. Optional: CHECK_ALLOW_UPPER_EN.
module decrypted_message_checker
  import rc4_check_pkg::*;
#(
  parameter int MSG_LEN = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_address,
  input  logic [7:0]        wr_data,
  input  logic              decrypt_finish,
  output logic              key_is_wrong,
  output logic              key_found,
  output logic              key_bad,
  output logic              done,
  output logic [ADDR_W-1:0] error_index,
  output logic [ADDR_W:0]   valid_count
);

  localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W+1)'(MSG_LEN - 1);

  checker_state_t    state;
  logic [ADDR_W-1:0] exp_addr;
  logic              legal;
  logic              wr_ok;

  char_validator u_char_validator (
    .data  (wr_data),
    .legal (legal)
  );

  assign wr_ok = legal && (wr_address == exp_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      exp_addr     <= '0;
      key_is_wrong <= 1'b0;
      key_found    <= 1'b0;
      key_bad      <= 1'b0;
      done         <= 1'b0;
      error_index  <= '0;
      valid_count  <= '0;
    end else begin
      // pulses default low; only one cycle ever asserts them
      key_is_wrong <= 1'b0;
      done         <= 1'b0;
      if (start) begin
        state       <= ST_MONITOR;
        exp_addr    <= '0;
        key_found   <= 1'b0;
        key_bad     <= 1'b0;
        error_index <= '0;
        valid_count <= '0;
      end else begin
        case (state)
          ST_MONITOR: begin
            if (wr_en) begin
              if (wr_ok) begin
                valid_count <= valid_count + 1'b1;
                exp_addr    <= exp_addr + 1'b1;
                if (valid_count == LAST_COUNT) state <= ST_WAIT_FIN;
              end else begin
                key_is_wrong <= 1'b1;
                key_bad      <= 1'b1;
                done         <= 1'b1;
                error_index  <= wr_address;
                state        <= ST_BAD;
              end
            end else if (decrypt_finish) begin
              // decryptor already finished, so no abort pulse is needed
              key_bad     <= 1'b1;
              done        <= 1'b1;
              error_index <= exp_addr;
              state       <= ST_BAD;
            end
          end
          ST_WAIT_FIN: begin
            if (wr_en) begin
              key_is_wrong <= 1'b1;
              key_bad      <= 1'b1;
              done         <= 1'b1;
              error_index  <= wr_address;
              state        <= ST_BAD;
            end else if (decrypt_finish) begin
              key_found <= 1'b1;
              done      <= 1'b1;
              state     <= ST_FOUND;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decrypted_message_checker.sv
// Table-driven bench for decrypted_message_checker with an expected-output scoreboard.
module tb_decrypted_message_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       wr_en;
  logic [4:0] wr_address;
  logic [7:0] wr_data;
  logic       decrypt_finish;
  logic       key_is_wrong;
  logic       key_found;
  logic       key_bad;
  logic       done;
  logic [4:0] error_index;
  logic [5:0] valid_count;

  decrypted_message_checker #(.MSG_LEN(32), .ADDR_W(5)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .wr_en          (wr_en),
    .wr_address     (wr_address),
    .wr_data        (wr_data),
    .decrypt_finish (decrypt_finish),
    .key_is_wrong   (key_is_wrong),
    .key_found      (key_found),
    .key_bad        (key_bad),
    .done           (done),
    .error_index    (error_index),
    .valid_count    (valid_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       kiw;
    logic       kf;
    logic       kb;
    logic       dn;
    logic [4:0] ei;
    logic [5:0] vc;
  } out_t;

  typedef struct packed {
    logic       rst;
    logic       st;
    logic       we;
    logic [4:0] a;
    logic [7:0] d;
    logic       fin;
    out_t       exp;
  } vec_t;

  vec_t tbl[$];
  out_t sb_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic out_t o(input logic kiw, kf, kb, dn, input int ei, input int vc);
    out_t r;
    r.kiw = kiw; r.kf = kf; r.kb = kb; r.dn = dn;
    r.ei = 5'(ei); r.vc = 6'(vc);
    return r;
  endfunction

  function automatic vec_t mkv(input logic r, s, w, input int a, input int d,
                               input logic f, input out_t e);
    vec_t v;
    v.rst = r; v.st = s; v.we = w; v.a = 5'(a); v.d = 8'(d); v.fin = f; v.exp = e;
    return v;
  endfunction

  function automatic int msg(input int i);
    return (i < 26) ? (8'h61 + i) : 8'h20;
  endfunction

  task automatic add(input vec_t v);
    tbl.push_back(v);
  endtask

  // Drive one cycle of inputs, expect the registered outputs after the edge.
  task automatic step(input vec_t v, input string tag);
    out_t act, exp;
    reset = v.rst; start = v.st; wr_en = v.we;
    wr_address = v.a; wr_data = v.d; decrypt_finish = v.fin;
    sb_q.push_back(v.exp);
    @(posedge clk);
    #1;
    act = {key_is_wrong, key_found, key_bad, done, error_index, valid_count};
    n_vec++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s vec%0d: scoreboard empty, got kiw=%0b kf=%0b kb=%0b dn=%0b ei=%0d vc=%0d",
               tag, n_vec, act.kiw, act.kf, act.kb, act.dn, act.ei, act.vc);
    end else begin
      exp = sb_q.pop_front();
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s vec%0d: got kiw=%0b kf=%0b kb=%0b dn=%0b ei=%0d vc=%0d, want kiw=%0b kf=%0b kb=%0b dn=%0b ei=%0d vc=%0d",
                 tag, n_vec, act.kiw, act.kf, act.kb, act.dn, act.ei, act.vc,
                 exp.kiw, exp.kf, exp.kb, exp.dn, exp.ei, exp.vc);
      end
    end
  endtask

  initial begin
    out_t z;
    z = o(0, 0, 0, 0, 0, 0);
    reset = 1'b1; start = 1'b0; wr_en = 1'b0;
    wr_address = '0; wr_data = '0; decrypt_finish = 1'b0;

    // reset state and idle writes ignored
    add(mkv(1, 0, 0, 0, 0, 0, z));
    add(mkv(1, 0, 0, 0, 0, 0, z));
    add(mkv(0, 0, 1, 0, 8'h61, 0, z));
    add(mkv(0, 0, 0, 0, 0, 1, z));

    // full legal message then finish
    add(mkv(0, 1, 0, 0, 0, 0, z));
    for (int i = 0; i < 32; i++) add(mkv(0, 0, 1, i, msg(i), 0, o(0, 0, 0, 0, 0, i + 1)));
    add(mkv(0, 0, 0, 0, 0, 1, o(0, 1, 0, 1, 0, 32)));
    add(mkv(0, 0, 0, 0, 0, 0, o(0, 1, 0, 0, 0, 32)));
    add(mkv(0, 0, 1, 3, 8'h7B, 1, o(0, 1, 0, 0, 0, 32)));

    // illegal byte at address 5
    add(mkv(0, 1, 0, 0, 0, 0, z));
    for (int i = 0; i < 5; i++) add(mkv(0, 0, 1, i, msg(i), 0, o(0, 0, 0, 0, 0, i + 1)));
    add(mkv(0, 0, 1, 5, 8'h7B, 0, o(1, 0, 1, 1, 5, 5)));
    add(mkv(0, 0, 1, 6, 8'h61, 0, o(0, 0, 1, 0, 5, 5)));
    add(mkv(0, 0, 1, 7, 8'h7B, 1, o(0, 0, 1, 0, 5, 5)));

    // address skip
    add(mkv(0, 1, 0, 0, 0, 0, z));
    add(mkv(0, 0, 1, 0, 8'h61, 0, o(0, 0, 0, 0, 0, 1)));
    add(mkv(0, 0, 1, 2, 8'h62, 0, o(1, 0, 1, 1, 2, 1)));
    add(mkv(0, 0, 0, 0, 0, 0, o(0, 0, 1, 0, 2, 1)));

    // early finish after 10 bytes
    add(mkv(0, 1, 0, 0, 0, 0, z));
    for (int i = 0; i < 10; i++) add(mkv(0, 0, 1, i, msg(i), 0, o(0, 0, 0, 0, 0, i + 1)));
    add(mkv(0, 0, 0, 0, 0, 1, o(0, 0, 1, 1, 10, 10)));
    add(mkv(0, 0, 0, 0, 0, 0, o(0, 0, 1, 0, 10, 10)));

    // uppercase at address 0
    add(mkv(0, 1, 0, 0, 0, 0, z));
`ifdef CHECK_ALLOW_UPPER_EN
    add(mkv(0, 0, 1, 0, 8'h41, 0, o(0, 0, 0, 0, 0, 1)));
    add(mkv(0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 1)));
`else
    add(mkv(0, 0, 1, 0, 8'h41, 0, o(1, 0, 1, 1, 0, 0)));
    add(mkv(0, 0, 0, 0, 0, 0, o(0, 0, 1, 0, 0, 0)));
`endif

    // extra write while waiting for finish
    add(mkv(0, 1, 0, 0, 0, 0, z));
    for (int i = 0; i < 32; i++) add(mkv(0, 0, 1, i, msg(i), 0, o(0, 0, 0, 0, 0, i + 1)));
    add(mkv(0, 0, 1, 0, 8'h61, 0, o(1, 0, 1, 1, 0, 32)));
    add(mkv(0, 0, 0, 0, 0, 1, o(0, 0, 1, 0, 0, 32)));

    @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], "table");

    // reset mid-stream, then a clean full attempt
    step(mkv(0, 1, 0, 0, 0, 0, z), "rst_mid");
    for (int i = 0; i < 3; i++) step(mkv(0, 0, 1, i, msg(i), 0, o(0, 0, 0, 0, 0, i + 1)), "rst_mid");
    step(mkv(1, 0, 1, 3, msg(3), 0, z), "rst_mid");
    step(mkv(0, 0, 1, 0, 8'h61, 0, z), "rst_idle");
    step(mkv(0, 1, 0, 0, 0, 0, z), "rst_retry");
    for (int i = 0; i < 32; i++) step(mkv(0, 0, 1, i, msg(i), 0, o(0, 0, 0, 0, 0, i + 1)), "rst_retry");
    step(mkv(0, 0, 0, 0, 0, 1, o(0, 1, 0, 1, 0, 32)), "rst_retry");

    // reset while the abort pulse is high
    step(mkv(0, 1, 0, 0, 0, 0, z), "rst_pulse");
    step(mkv(0, 0, 1, 0, 8'h7B, 0, o(1, 0, 1, 1, 0, 0)), "rst_pulse");
    step(mkv(1, 0, 0, 0, 0, 0, z), "rst_pulse");

    // restart mid-attempt with a simultaneous write: start wins
    step(mkv(0, 1, 0, 0, 0, 0, z), "restart");
    step(mkv(0, 0, 1, 0, 8'h61, 0, o(0, 0, 0, 0, 0, 1)), "restart");
    step(mkv(0, 0, 1, 1, 8'h62, 0, o(0, 0, 0, 0, 0, 2)), "restart");
    step(mkv(0, 1, 1, 2, 8'h63, 0, z), "restart");
    step(mkv(0, 0, 1, 0, 8'h61, 0, o(0, 0, 0, 0, 0, 1)), "restart");
    step(mkv(0, 0, 1, 5, 8'h61, 0, o(1, 0, 1, 1, 5, 1)), "restart");
    step(mkv(0, 0, 0, 0, 0, 0, o(0, 0, 1, 0, 5, 1)), "restart");

    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
